// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Input-side skew feeder for the systolic array. Accepts one ARRAY_SIZE-wide
// operand vector per cycle over valid/ready. Each vector is re-timed into the
// diagonal wavefront the array consumes: lane i is delayed i cycles. At the end
// of each tile the feeder drains the wavefront before it accepts the next tile.
//
// Parameters
//   ARRAY_SIZE  number of lanes (array rows), >= 1
//   BITWIDTH    bits per element
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   in_data / in_last are valid
//   in_ready   feeder accepts a vector this cycle (combinational)
//   in_data    operand vector, element i = [i*BITWIDTH +: BITWIDTH]
//   in_last    accepted vector is the final one of the tile
//   stall      array back-pressure, freezes the whole feeder
//   arr_data   skewed lane data to the array, same packing as in_data
//   arr_valid  per-lane valid
//   tile_done  one-cycle pulse as the tile's last element leaves the top lane
//   busy       registered, high from the cycle after the first accept of a
//              tile through the tile_done cycle
//
// Build option
//   SYSTOLIC_FEEDER_ZERO_PAD_EN  when defined, every invalid slot (bubble,
//   flush, reset) carries data 0, so arr_data is 0 wherever arr_valid is 0.
//   When undefined, invalid-slot data is don't-care and the zeroing mux is
//   removed. Valid behaviour and timing are identical in both builds.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int BITWIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ARRAY_SIZE*BITWIDTH-1:0] in_data,
  input  logic                           in_last,
  input  logic                           stall,
  output logic [ARRAY_SIZE*BITWIDTH-1:0] arr_data,
  output logic [ARRAY_SIZE-1:0]          arr_valid,
  output logic                           tile_done,
  output logic                           busy
);

  // The flush counter counts 0 .. ARRAY_SIZE-1; keep at least one bit so the
  // single-lane build still has a legal vector.
  localparam int                CNT_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARRAY_SIZE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]                    r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_busy;
  logic                          w_accept;
  logic                          w_flush_end;
  logic [ARRAY_SIZE*BITWIDTH-1:0] w_head_data;

  // in_ready depends only on stall and state, so it is meaningful in reset too.
  assign in_ready = !stall && (r_state != ST_FLUSH);
  assign w_accept = in_valid && in_ready;

  // The counter starts at 0 in the first FLUSH cycle; when it reaches
  // ARRAY_SIZE-1 the last element is on the top lane's output register.
  // A stalled cycle never ends the flush, which defers tile_done.
  assign w_flush_end = (r_state == ST_FLUSH) && (r_cnt == CNT_LAST) && !stall;
  assign tile_done   = w_flush_end;
  assign busy        = r_busy;

`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
  // Bubble and flush slots enter the chains as zero.
  assign w_head_data = w_accept ? in_data : '0;
`else
  assign w_head_data = in_data;
`endif

  // ---------------------------------------------------------------------------
  // Tile state machine
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the chains shift in lockstep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!stall) begin
      case (r_state)
        ST_IDLE, ST_FEED: begin
          if (w_accept) begin
            r_state <= in_last ? ST_FLUSH : ST_FEED;
            r_cnt   <= '0;
          end
        end
        ST_FLUSH: begin
          if (w_flush_end) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // busy rises after the first accept and falls after tile_done. The two can
  // never coincide because nothing is accepted during FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_busy <= 1'b0;
    else if (tile_done) r_busy <= 1'b0;
    else if (w_accept)  r_busy <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Lane chains: lane g holds g+1 stages of {valid, element g}; the last stage
  // is the output register seen by the array.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    logic [BITWIDTH-1:0] r_dat [0:g];
    logic                r_vld [0:g];

    // NOTE: these shift-register arrays are reset in full (not left
    // uninitialised like a RAM) because outputs must read 0 out of reset and a
    // mid-tile reset must discard every in-flight element.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= g; k++) begin
          r_dat[k] <= '0;
          r_vld[k] <= 1'b0;
        end
      end else if (!stall) begin
        r_dat[0] <= w_head_data[g*BITWIDTH +: BITWIDTH];
        r_vld[0] <= w_accept;
        for (int k = 1; k <= g; k++) begin
          r_dat[k] <= r_dat[k-1];
          r_vld[k] <= r_vld[k-1];
        end
      end
    end

    assign arr_data[g*BITWIDTH +: BITWIDTH] = r_dat[g];
    assign arr_valid[g]                     = r_vld[g];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder with ARRAY_SIZE=4, BITWIDTH=8. Each cycle
// drives the inputs just after the rising edge and compares arr_valid, the
// valid bytes of arr_data (all bytes when SYSTOLIC_FEEDER_ZERO_PAD_EN is
// defined), tile_done, in_ready and busy against hand-computed tables.
// Cycle numbers in the tags count from the first cycle of each scenario.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_last;
  logic           stall;
  logic [N*W-1:0] arr_data;
  logic [N-1:0]   arr_valid;
  logic           tile_done;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  systolic_feeder #(.ARRAY_SIZE(N), .BITWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .stall     (stall),
    .arr_data  (arr_data),
    .arr_valid (arr_valid),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs of that cycle, advance to the
  // next cycle (leaves time at rising edge + 1).
  task automatic run_cycle(input string tag,
                           input logic v, input logic [31:0] d, input logic l, input logic s,
                           input logic [3:0] ev, input logic [31:0] ed,
                           input logic edone, input logic erdy, input logic ebusy);
    logic [31:0] mask;
    string       t;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    stall    = s;
    #2;
    mask = '0;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
    mask = '1;
`else
    for (int i = 0; i < N; i++) if (ev[i]) mask[i*W +: W] = '1;
`endif
    t = $sformatf("%s c%0d", tag, cyc);
    check({t, " arr_valid"}, 32'(arr_valid), 32'(ev));
    check({t, " arr_data"},  arr_data & mask, ed & mask);
    check({t, " tile_done"}, 32'(tile_done), 32'(edone));
    check({t, " in_ready"},  32'(in_ready),  32'(erdy));
    check({t, " busy"},      32'(busy),      32'(ebusy));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    run_cycle(tag, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  // Two-vector tile from power-up-like state; lane0 at c1/c2, lane3 at c4/c5.
  task automatic single_tile(input string tag);
    cyc = 0;
    run_cycle(tag, 1, 32'h04030201, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle(tag, 1, 32'h08070605, 1, 0, 4'b0001, 32'h00000001, 0, 1, 1);
    run_cycle(tag, 0, 32'h0,        0, 0, 4'b0011, 32'h00000205, 0, 0, 1);
    run_cycle(tag, 0, 32'h0,        0, 0, 4'b0110, 32'h00030600, 0, 0, 1);
    run_cycle(tag, 0, 32'h0,        0, 0, 4'b1100, 32'h04070000, 0, 0, 1);
    run_cycle(tag, 0, 32'h0,        0, 0, 4'b1000, 32'h08000000, 1, 0, 1);
    idle_cycle(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    stall    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("reset arr_valid", 32'(arr_valid), 32'h0);
    check("reset arr_data",  arr_data,       32'h0);
    check("reset tile_done", 32'(tile_done), 32'h0);
    check("reset busy",      32'(busy),      32'h0);
    check("reset in_ready",  32'(in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    single_tile("single");

    // Bubble in cycle 1: every lane shows a valid-0 slot between A and B.
    cyc = 0;
    run_cycle("bubble", 1, 32'h14131211, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("bubble", 0, 32'hDEADBEEF, 0, 0, 4'b0001, 32'h00000011, 0, 1, 1);
    run_cycle("bubble", 1, 32'h24232221, 1, 0, 4'b0010, 32'h00001200, 0, 1, 1);
    run_cycle("bubble", 0, 32'h0,        0, 0, 4'b0101, 32'h00130021, 0, 0, 1);
    run_cycle("bubble", 0, 32'h0,        0, 0, 4'b1010, 32'h14002200, 0, 0, 1);
    run_cycle("bubble", 0, 32'h0,        0, 0, 4'b0100, 32'h00230000, 0, 0, 1);
    run_cycle("bubble", 0, 32'h0,        0, 0, 4'b1000, 32'h24000000, 1, 0, 1);
    idle_cycle("bubble");

    // Stall in cycles 2-3 of a 3-vector tile: outputs frozen, tile_done at c8.
    cyc = 0;
    run_cycle("stall", 1, 32'h34333231, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("stall", 1, 32'h44434241, 0, 0, 4'b0001, 32'h00000031, 0, 1, 1);
    run_cycle("stall", 1, 32'h54535251, 1, 1, 4'b0011, 32'h00003241, 0, 0, 1);
    run_cycle("stall", 1, 32'h54535251, 1, 1, 4'b0011, 32'h00003241, 0, 0, 1);
    run_cycle("stall", 1, 32'h54535251, 1, 0, 4'b0011, 32'h00003241, 0, 1, 1);
    run_cycle("stall", 0, 32'h0,        0, 0, 4'b0111, 32'h00334251, 0, 0, 1);
    run_cycle("stall", 0, 32'h0,        0, 0, 4'b1110, 32'h34435200, 0, 0, 1);
    run_cycle("stall", 0, 32'h0,        0, 0, 4'b1100, 32'h44530000, 0, 0, 1);
    run_cycle("stall", 0, 32'h0,        0, 0, 4'b1000, 32'h54000000, 1, 0, 1);
    idle_cycle("stall");

    // 1-vector tiles back to back; the second one stalls in its done cycle,
    // deferring tile_done by one cycle.
    cyc = 0;
    run_cycle("one", 1, 32'h64636261, 1, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0001, 32'h00000061, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0010, 32'h00006200, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0100, 32'h00630000, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b1000, 32'h64000000, 1, 0, 1);
    run_cycle("one", 1, 32'h74737271, 1, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0001, 32'h00000071, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0010, 32'h00007200, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b0100, 32'h00730000, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 1, 4'b1000, 32'h74000000, 0, 0, 1);
    run_cycle("one", 0, 32'h0,        0, 0, 4'b1000, 32'h74000000, 1, 0, 1);
    idle_cycle("one");

    // Reset in cycle 3, after lane1 emitted A: everything clears at once.
    cyc = 0;
    run_cycle("rstmid", 1, 32'h84838281, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("rstmid", 1, 32'h94939291, 1, 0, 4'b0001, 32'h00000081, 0, 1, 1);
    run_cycle("rstmid", 0, 32'h0,        0, 0, 4'b0011, 32'h00008291, 0, 0, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("rstmid c3 arr_valid", 32'(arr_valid), 32'h0);
    check("rstmid c3 busy",      32'(busy),      32'h0);
    check("rstmid c3 tile_done", 32'(tile_done), 32'h0);
    check("rstmid c3 in_ready",  32'(in_ready),  32'h1);
    #3;
    rst = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle_cycle("rstmid");
    single_tile("after_rst");

    // Back-to-back 2-vector tiles, in_valid held high through the flush gap.
    cyc = 0;
    run_cycle("b2b", 1, 32'hA4A3A2A1, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("b2b", 1, 32'hB4B3B2B1, 1, 0, 4'b0001, 32'h000000A1, 0, 1, 1);
    run_cycle("b2b", 1, 32'hC4C3C2C1, 0, 0, 4'b0011, 32'h0000A2B1, 0, 0, 1);
    run_cycle("b2b", 1, 32'hC4C3C2C1, 0, 0, 4'b0110, 32'h00A3B200, 0, 0, 1);
    run_cycle("b2b", 1, 32'hC4C3C2C1, 0, 0, 4'b1100, 32'hA4B30000, 0, 0, 1);
    run_cycle("b2b", 1, 32'hC4C3C2C1, 0, 0, 4'b1000, 32'hB4000000, 1, 0, 1);
    run_cycle("b2b", 1, 32'hC4C3C2C1, 0, 0, 4'b0000, 32'h00000000, 0, 1, 0);
    run_cycle("b2b", 1, 32'hD4D3D2D1, 1, 0, 4'b0001, 32'h000000C1, 0, 1, 1);
    run_cycle("b2b", 1, 32'hE4E3E2E1, 0, 0, 4'b0011, 32'h0000C2D1, 0, 0, 1);
    run_cycle("b2b", 1, 32'hE4E3E2E1, 0, 0, 4'b0110, 32'h00C3D200, 0, 0, 1);
    run_cycle("b2b", 1, 32'hE4E3E2E1, 0, 0, 4'b1100, 32'hC4D30000, 0, 0, 1);
    run_cycle("b2b", 1, 32'hE4E3E2E1, 0, 0, 4'b1000, 32'hD4000000, 1, 0, 1);
    idle_cycle("b2b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
